// File: rtl/frame_phase_scheduler.sv
// frame_phase_scheduler: sequences one animation step of a game object.
// Erase the old sprite, advance the position, draw the new sprite, then hold
// for WAIT_FRAMES video frames. The erase and draw jobs share one pixel engine
// through a go/done handshake. A bounded wait on draw_done keeps a stuck
// engine from hanging the sequence.
//
// Every output is a flop. The pulse outputs and busy are decoded from the
// next state, so each one lines up with the state it belongs to.
// frame_tick is issued one cycle early from the divider, so it shows during
// the last cycle of each frame.
// CLKS_PER_FRAME must be at least 2, WAIT_FRAMES at least 1 and
// DONE_TIMEOUT at least 1.
module frame_phase_scheduler #(
  parameter int CLKS_PER_FRAME = 833334,
  parameter int WAIT_FRAMES    = 6,
  parameter int DONE_TIMEOUT   = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       pause,
  input  logic       draw_done,
  output logic       erase_go,
  output logic       draw_go,
  output logic       update_en,
  output logic       frame_tick,
  output logic       busy,
  output logic       timeout,
  output logic [2:0] state
);

  localparam int DIV_W  = (CLKS_PER_FRAME > 1) ? $clog2(CLKS_PER_FRAME) : 1;
  localparam int FCNT_W = (WAIT_FRAMES > 0) ? $clog2(WAIT_FRAMES + 1) : 1;
  localparam int TCNT_W = (DONE_TIMEOUT > 0) ? $clog2(DONE_TIMEOUT + 1) : 1;

  // Last divider value of a frame, and the value one before it.
  // frame_tick is issued from the second of these.
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLKS_PER_FRAME - 1);
  localparam logic [DIV_W-1:0]  DIV_PRE   = DIV_W'(CLKS_PER_FRAME - 2);
  // The frame count compared on the final tick. The count becomes
  // WAIT_FRAMES on the same edge that leaves WAIT.
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(WAIT_FRAMES - 1);
  // Count value in the last allowed cycle of a draw_done wait.
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ERASE_REQ  = 3'd1,
    ERASE_WAIT = 3'd2,
    UPDATE     = 3'd3,
    DRAW_REQ   = 3'd4,
    DRAW_WAIT  = 3'd5,
    WAIT       = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                timeout_q, timeout_d;
  logic                tick_d;
  logic                erase_go_q, draw_go_q, update_en_q, frame_tick_q, busy_q;

  // Next-state logic plus the divider, frame and timeout counters.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    fcnt_d    = fcnt_q;
    tcnt_d    = tcnt_q;
    timeout_d = timeout_q;
    tick_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run) state_d = ERASE_REQ;
      end
      ERASE_REQ: begin
        tcnt_d  = '0;
        state_d = ERASE_WAIT;
      end
      ERASE_WAIT: begin
        if (draw_done) begin
          state_d = UPDATE;
        end else if (tcnt_q == TCNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = UPDATE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      UPDATE: begin
        state_d = DRAW_REQ;
      end
      DRAW_REQ: begin
        tcnt_d  = '0;
        state_d = DRAW_WAIT;
      end
      DRAW_WAIT: begin
        if (draw_done || tcnt_q == TCNT_LAST) begin
          if (!draw_done) timeout_d = 1'b1;
          div_d   = '0;
          fcnt_d  = '0;
          state_d = WAIT;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      WAIT: begin
        // While paused, the divider and frame count hold and no tick is issued.
        if (!pause) begin
          if (div_q == DIV_LAST) begin
            div_d  = '0;
            fcnt_d = fcnt_q + 1'b1;
            if (fcnt_q == FCNT_LAST) state_d = run ? ERASE_REQ : IDLE;
          end else begin
            div_d  = div_q + 1'b1;
            tick_d = (div_q == DIV_PRE);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs. Reset drops any pulse in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      div_q        <= '0;
      fcnt_q       <= '0;
      tcnt_q       <= '0;
      timeout_q    <= 1'b0;
      erase_go_q   <= 1'b0;
      draw_go_q    <= 1'b0;
      update_en_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      fcnt_q       <= fcnt_d;
      tcnt_q       <= tcnt_d;
      timeout_q    <= timeout_d;
      erase_go_q   <= (state_d == ERASE_REQ);
      draw_go_q    <= (state_d == DRAW_REQ);
      update_en_q  <= (state_d == UPDATE);
      frame_tick_q <= tick_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  assign erase_go   = erase_go_q;
  assign draw_go    = draw_go_q;
  assign update_en  = update_en_q;
  assign frame_tick = frame_tick_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;
  assign state      = state_q;

endmodule
